// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Iterative unsigned multiply/divide execute unit. It takes its operands from
//   the register file read ports and drives the register file write port. Every
//   operation runs exactly XLEN iterations, one per cycle. The done pulse comes
//   XLEN+1 cycles after the start is accepted.
//
//   Ports
//     clk     : system clock, rising edge
//     reset   : asynchronous, active-low reset
//     start   : request a new operation (accepted in IDLE or DONE)
//     op      : 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//     src_a   : multiplicand / dividend
//     src_b   : multiplier / divisor
//     rd      : destination register index
//     flush   : abort the in-flight operation (wins over start)
//     busy    : high while an operation is iterating
//     done    : one-cycle result-valid pulse
//     result  : operation result, held until the next done
//     rd_out  : destination index of the last completed operation
//     wr_en   : register-file write strobe (done with a non-zero rd_out)
// -----------------------------------------------------------------------------
module mul_div_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic [4:0]      rd,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic            wr_en
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t            state_reg, state_next;
   logic [1:0]        op_reg;
   logic [XLEN:0]     hi_reg;      // upper product half / partial remainder
   logic [XLEN-1:0]   lo_reg;      // lower product half / dividend-quotient
   logic [XLEN-1:0]   opnd_reg;    // multiplicand / divisor
   logic [CNT_W-1:0]  counter_reg;
   logic [4:0]        rd_reg;

   logic              accept;
   logic              last_iter;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic [XLEN+1:0]   div_diff;
   logic              div_ok;
   logic [XLEN:0]     hi_step;
   logic [XLEN-1:0]   lo_step;
   logic [XLEN-1:0]   final_value;

   // A start is taken in IDLE and also in DONE, which allows back-to-back issue.
   assign accept    = (state_reg != ST_RUN) && start && !flush;
   assign last_iter = (counter_reg == CNT_W'(XLEN - 1));

   // One iteration of the datapath. For multiply, the multiplier sits in lo_reg
   // and shifts out LSB-first while the product grows into hi:lo. For divide,
   // the dividend shifts out MSB-first into the partial remainder, and the
   // quotient bits shift into lo_reg. A zero divisor always subtracts
   // successfully, so it yields all-ones / dividend without special handling.
   always_comb begin
      mul_sum   = hi_reg + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
      div_shift = {hi_reg[XLEN-1:0], lo_reg[XLEN-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, opnd_reg};
      div_ok    = !div_diff[XLEN+1];
      hi_step   = '0;
      lo_step   = '0;
      if (op_reg[1]) begin
         hi_step = div_ok ? div_diff[XLEN:0] : div_shift;
         lo_step = {lo_reg[XLEN-2:0], div_ok};
      end else begin
         hi_step = {1'b0, mul_sum[XLEN:1]};
         lo_step = {mul_sum[0], lo_reg[XLEN-1:1]};
      end
      // op[0] picks the high half (MULHU / REMU) or the low half (MUL / DIVU).
      final_value = op_reg[0] ? hi_step[XLEN-1:0] : lo_step;
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: state_next = accept ? ST_RUN : ST_IDLE;
         ST_RUN: begin
            if (flush) begin
               state_next = ST_IDLE;
            end else if (last_iter) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: state_next = accept ? ST_RUN : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy  = (state_reg == ST_RUN);
      done  = (state_reg == ST_DONE);
      wr_en = (state_reg == ST_DONE) && (rd_out != 5'd0);
   end

   // Datapath registers. The result and rd_out load on the final iteration,
   // which is the same edge that enters DONE. A flush suppresses that load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_reg      <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         opnd_reg    <= '0;
         counter_reg <= '0;
         rd_reg      <= '0;
         result      <= '0;
         rd_out      <= '0;
      end else if (accept) begin
         op_reg      <= op;
         hi_reg      <= '0;
         lo_reg      <= src_a;
         opnd_reg    <= src_b;
         counter_reg <= '0;
         rd_reg      <= rd;
      end else if (state_reg == ST_RUN && !flush) begin
         hi_reg      <= hi_step;
         lo_reg      <= lo_step;
         counter_reg <= counter_reg + CNT_W'(1);
         if (last_iter) begin
            result <= final_value;
            rd_out <= rd_reg;
         end
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic [4:0]      rd;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;
   logic            wr_en;

   int checks = 0;
   int errors = 0;
   logic [XLEN-1:0] last_result;
   logic [4:0]      last_rd;

   mul_div_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .src_a  (src_a),
      .src_b  (src_b),
      .rd     (rd),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .result (result),
      .rd_out (rd_out),
      .wr_en  (wr_en)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain wide arithmetic plus the divide-by-zero rules.
   function automatic logic [XLEN-1:0] model(input logic [1:0] o,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
      logic [2*XLEN-1:0] p;
      p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
      case (o)
         2'd0:    return p[XLEN-1:0];
         2'd1:    return p[2*XLEN-1:XLEN];
         2'd2:    return (b == '0) ? '1 : a / b;
         default: return (b == '0) ? a : a % b;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_start(input logic [1:0] o, input logic [XLEN-1:0] a,
                              input logic [XLEN-1:0] b, input logic [4:0] r);
      start = 1'b1;
      flush = 1'b0;
      op    = o;
      src_a = a;
      src_b = b;
      rd    = r;
   endtask

   // Called with a start already driven. Returns #1 after the edge that enters
   // DONE, so the caller can issue back-to-back from the DONE cycle.
   task automatic wait_done(input logic [1:0] o, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b, input logic [4:0] r,
                            input bit poke_mid, input string tag);
      logic [XLEN-1:0] exp;
      bit early_done;
      bit busy_drop;
      exp = model(o, a, b);
      tick();                       // edge N: start sampled
      start = 1'b0;
      op    = 2'($urandom);         // operands are not sampled after start
      src_a = $urandom;
      src_b = $urandom;
      rd    = 5'($urandom);
      check({tag, "_busy_on"}, 64'(busy), 64'd1);
      early_done = 1'b0;
      busy_drop  = 1'b0;
      for (int k = 1; k <= XLEN; k++) begin
         if (poke_mid && k == 5) start = 1'b1;
         if (k == 6) start = 1'b0;
         tick();
         if (k < XLEN) begin
            if (done) early_done = 1'b1;
            if (!busy) busy_drop = 1'b1;
         end
      end
      check({tag, "_early_done"}, 64'(early_done), 64'd0);
      check({tag, "_busy_drop"}, 64'(busy_drop), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_busy_off"}, 64'(busy), 64'd0);
      check({tag, "_result"}, 64'(result), 64'(exp));
      check({tag, "_rd_out"}, 64'(rd_out), 64'(r));
      check({tag, "_wr_en"}, 64'(wr_en), 64'(r != 5'd0));
      $display("op=%0d a=%08h b=%08h rd=%0d result=%08h expected=%08h", o, a, b, r, result, exp);
      last_result = exp;
      last_rd     = r;
   endtask

   task automatic run_one(input logic [1:0] o, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [4:0] r, input string tag);
      drive_start(o, a, b, r);
      wait_done(o, a, b, r, 1'b0, tag);
      tick();
      check({tag, "_done_single"}, 64'(done), 64'd0);
   endtask

   initial begin
      logic [1:0]      ro;
      logic [XLEN-1:0] ra;
      logic [XLEN-1:0] rb;
      logic [4:0]      rr;
      bit              seen_done;

      reset = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      op    = '0;
      src_a = '0;
      src_b = '0;
      rd    = '0;
      last_result = '0;
      last_rd     = '0;
      repeat (3) tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_rd_out", 64'(rd_out), 64'd0);
      check("rst_wr_en", 64'(wr_en), 64'd0);
      reset = 1'b1;
      tick();

      // Directed cases
      run_one(2'd0, 32'd7, 32'd6, 5'd5, "mul_7x6");
      run_one(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, "mulhu_ff");
      run_one(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "mul_ff");
      run_one(2'd2, 32'd100, 32'd7, 5'd3, "divu_100_7");
      run_one(2'd3, 32'd100, 32'd7, 5'd4, "remu_100_7");
      run_one(2'd2, 32'd5, 32'd0, 5'd6, "divu_by0");
      run_one(2'd3, 32'd5, 32'd0, 5'd7, "remu_by0");
      run_one(2'd2, 32'd99, 32'd4, 5'd0, "divu_rd0");

      // Flush at iteration 10
      drive_start(2'd0, 32'd123, 32'd456, 5'd9);
      tick();
      start = 1'b0;
      repeat (10) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_done", 64'(done), 64'd0);
      check("flush_result_kept", 64'(result), 64'(last_result));
      check("flush_rd_kept", 64'(rd_out), 64'(last_rd));
      seen_done = 1'b0;
      for (int k = 0; k < XLEN + 2; k++) begin
         tick();
         if (done) seen_done = 1'b1;
      end
      check("flush_no_done", 64'(seen_done), 64'd0);

      // Flush beats start in the same cycle
      drive_start(2'd2, 32'd50, 32'd5, 5'd8);
      flush = 1'b1;
      tick();
      start = 1'b0;
      flush = 1'b0;
      check("flush_vs_start_busy", 64'(busy), 64'd0);

      // Reset mid-RUN
      drive_start(2'd2, 32'd1000, 32'd3, 5'd10);
      tick();
      start = 1'b0;
      repeat (7) tick();
      reset = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_result", 64'(result), 64'd0);
      check("midrst_rd_out", 64'(rd_out), 64'd0);
      check("midrst_wr_en", 64'(wr_en), 64'd0);
      tick();
      reset = 1'b1;
      last_result = '0;
      last_rd     = '0;
      seen_done = 1'b0;
      for (int k = 0; k < XLEN + 2; k++) begin
         tick();
         if (done) seen_done = 1'b1;
      end
      check("midrst_no_done", 64'(seen_done), 64'd0);

      // Back-to-back issue from DONE, with a stray start mid-RUN
      drive_start(2'd0, 32'd1234, 32'd5678, 5'd11);
      wait_done(2'd0, 32'd1234, 32'd5678, 5'd11, 1'b1, "b2b_first");
      drive_start(2'd3, 32'd1000, 32'd33, 5'd12);
      wait_done(2'd3, 32'd1000, 32'd33, 5'd12, 1'b1, "b2b_second");
      tick();
      check("b2b_done_single", 64'(done), 64'd0);

      // Randomized operations, sometimes chained back-to-back
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom);
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: ra = '1;
            2: rb = 32'($urandom_range(1, 15));
            3: ra = '0;
            default: ;
         endcase
         rr = 5'($urandom_range(0, 31));
         drive_start(ro, ra, rb, rr);
         wait_done(ro, ra, rb, rr, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
         if ($urandom_range(0, 1) == 1) begin
            tick();
            check($sformatf("rand%0d_done_single", i), 64'(done), 64'd0);
         end
      end
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
